// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and default widths for the multi-issue reorder buffer
package rob_pkg;
   localparam int ROB_DEPTH_DEF = 32;
   localparam int ROB_XLEN      = 32;
   localparam int ROB_TAG_W     = $clog2(ROB_DEPTH_DEF);
   localparam int ROB_CNT_W     = ROB_TAG_W + 1;

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;

   typedef struct packed {
      logic                valid;
      logic                complete;
      logic                mispredict;
      logic [4:0]          dest_reg;
      logic [ROB_XLEN-1:0] pc;
      logic [ROB_XLEN-1:0] value;
      logic [ROB_XLEN-1:0] target;
   } rob_entry_t;
endpackage

// File: rtl/rob_retire_sel.sv
// rtl/rob_retire_sel.sv - in-order retire mask with mispredict cut over head-ordered entries
module rob_retire_sel #(
   parameter int RETIRE_W = 2
) (
   input  logic [RETIRE_W-1:0]              complete,
   input  logic [RETIRE_W-1:0]              mispredict,
   output logic [RETIRE_W-1:0]              retire_mask,
   output logic [$clog2(RETIRE_W+1)-1:0]    retire_cnt,
   output logic [RETIRE_W-1:0]              mp_cut
);
   localparam int CW = $clog2(RETIRE_W + 1);

   // A mispredicting lane still retires, but stops every younger lane.
   always_comb begin
      logic run;
      run         = 1'b1;
      retire_mask = '0;
      retire_cnt  = '0;
      mp_cut      = '0;
      for (int j = 0; j < RETIRE_W; j++) begin
         run            = run & complete[j];
         retire_mask[j] = run;
         mp_cut[j]      = run & mispredict[j];
         retire_cnt     = retire_cnt + CW'(run);
         run            = run & ~mispredict[j];
      end
   end
endmodule

// File: rtl/rob_nway.sv
// rtl/rob_nway.sv - multi-issue reorder buffer with in-order retire, mispredict redirect and CDB bypass
module rob_nway
   import rob_pkg::*;
#(
   parameter int ROB_DEPTH  = ROB_DEPTH_DEF,
   parameter int DISPATCH_W = 2,
   parameter int RETIRE_W   = 2,
   parameter int CDB_W      = 2,
   parameter int XLEN       = ROB_XLEN
) (
   input  logic                                      clock,
   input  logic                                      reset_n,
   input  logic                                      flush_in,
   input  logic [DISPATCH_W-1:0]                     dp_valid,
   input  logic [DISPATCH_W*5-1:0]                   dp_dest_reg,
   input  logic [DISPATCH_W*XLEN-1:0]                dp_pc,
   output logic [DISPATCH_W-1:0]                     dp_ready,
   output logic [DISPATCH_W*$clog2(ROB_DEPTH)-1:0]   dp_tag,
   input  logic [CDB_W-1:0]                          cdb_valid,
   input  logic [CDB_W*$clog2(ROB_DEPTH)-1:0]        cdb_tag,
   input  logic [CDB_W*XLEN-1:0]                     cdb_value,
   input  logic [CDB_W-1:0]                          cdb_mispredict,
   input  logic [CDB_W*XLEN-1:0]                     cdb_target,
   input  logic [2*DISPATCH_W*$clog2(ROB_DEPTH)-1:0] rd_tag,
   output logic [2*DISPATCH_W*XLEN-1:0]              rd_value,
   output logic [2*DISPATCH_W-1:0]                   rd_ready,
   output logic [RETIRE_W-1:0]                       rt_valid,
   output logic [RETIRE_W*5-1:0]                     rt_dest_reg,
   output logic [RETIRE_W*XLEN-1:0]                  rt_value,
   output logic [RETIRE_W*XLEN-1:0]                  rt_pc,
   output logic                                      br_flush,
   output logic [XLEN-1:0]                           br_target,
   output logic [$clog2(ROB_DEPTH):0]                count
);
   localparam int T    = $clog2(ROB_DEPTH);
   localparam int RD_N = 2 * DISPATCH_W;

   rob_entry_t ent [ROB_DEPTH];
   logic [T-1:0]                    head, tail;
   logic [T:0]                      free_cnt, n_dp, n_rt;
   logic [DISPATCH_W-1:0]           dp_acc;
   logic [RETIRE_W-1:0]             hd_complete, hd_mispredict, rt_mask, mp_cut;
   logic [$clog2(RETIRE_W+1)-1:0]   rt_cnt;
   logic                            mp_any;
   logic [XLEN-1:0]                 mp_target;

   assign free_cnt = (T+1)'(ROB_DEPTH) - count;
   assign n_rt     = (T+1)'(rt_cnt);
   assign mp_any   = |mp_cut;
   assign rt_valid = flush_in ? '0 : rt_mask;

   // Accept only a contiguous run of requesting lanes that fit in the free space.
   always_comb begin
      logic run;
      run      = 1'b1;
      n_dp     = '0;
      dp_acc   = '0;
      dp_ready = '0;
      dp_tag   = '0;
      for (int i = 0; i < DISPATCH_W; i++) begin
         dp_ready[i]       = free_cnt > (T+1)'(i);
         dp_tag[i*T +: T]  = tail + T'(i);
         run               = run & dp_valid[i] & dp_ready[i];
         dp_acc[i]         = run;
         n_dp              = n_dp + (T+1)'(run);
      end
   end

   always_comb begin
      logic [T-1:0] idx;
      idx           = '0;
      hd_complete   = '0;
      hd_mispredict = '0;
      rt_dest_reg   = '0;
      rt_value      = '0;
      rt_pc         = '0;
      mp_target     = '0;
      for (int j = 0; j < RETIRE_W; j++) begin
         idx              = head + T'(j);
         hd_complete[j]   = (count > (T+1)'(j)) && ent[idx].valid && ent[idx].complete;
         hd_mispredict[j] = ent[idx].mispredict;
         rt_dest_reg[j*5 +: 5]     = ent[idx].dest_reg;
         rt_value[j*XLEN +: XLEN]  = ent[idx].value;
         rt_pc[j*XLEN +: XLEN]     = ent[idx].pc;
         if (mp_cut[j])
            mp_target = ent[idx].target;
      end
   end

   rob_retire_sel #(.RETIRE_W(RETIRE_W)) u_retire_sel (
      .complete    (hd_complete),
      .mispredict  (hd_mispredict),
      .retire_mask (rt_mask),
      .retire_cnt  (rt_cnt),
      .mp_cut      (mp_cut)
   );

   // Operand lookup; a same-cycle broadcast wins, the highest CDB lane last.
   always_comb begin
      logic [T-1:0] t;
      t        = '0;
      rd_value = '0;
      rd_ready = '0;
      for (int k = 0; k < RD_N; k++) begin
         t = rd_tag[k*T +: T];
         rd_value[k*XLEN +: XLEN] = ent[t].value;
         rd_ready[k]              = ent[t].complete;
         for (int l = 0; l < CDB_W; l++) begin
            if (cdb_valid[l] && cdb_tag[l*T +: T] == t) begin
               rd_value[k*XLEN +: XLEN] = cdb_value[l*XLEN +: XLEN];
               rd_ready[k]              = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         br_flush  <= 1'b0;
         br_target <= '0;
         for (int e = 0; e < ROB_DEPTH; e++)
            ent[e] <= '0;
      end else begin
         for (int l = 0; l < CDB_W; l++) begin
            if (cdb_valid[l] && ent[cdb_tag[l*T +: T]].valid) begin
               ent[cdb_tag[l*T +: T]].complete   <= 1'b1;
               ent[cdb_tag[l*T +: T]].value      <= cdb_value[l*XLEN +: XLEN];
               ent[cdb_tag[l*T +: T]].mispredict <= cdb_mispredict[l];
               ent[cdb_tag[l*T +: T]].target     <= cdb_target[l*XLEN +: XLEN];
            end
         end
         if (!flush_in && !mp_any) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
               if (dp_acc[i]) begin
                  ent[tail + T'(i)].valid      <= 1'b1;
                  ent[tail + T'(i)].complete   <= 1'b0;
                  ent[tail + T'(i)].mispredict <= 1'b0;
                  ent[tail + T'(i)].dest_reg   <= dp_dest_reg[i*5 +: 5];
                  ent[tail + T'(i)].pc         <= dp_pc[i*XLEN +: XLEN];
               end
            end
         end
         for (int j = 0; j < RETIRE_W; j++) begin
            if (rt_valid[j])
               ent[head + T'(j)].valid <= 1'b0;
         end
         if (flush_in || mp_any) begin
            for (int e = 0; e < ROB_DEPTH; e++)
               ent[e].valid <= 1'b0;
         end

         if (flush_in) begin
            tail     <= head;
            count    <= '0;
            br_flush <= 1'b0;
         end else if (mp_any) begin
            head      <= head + T'(n_rt);
            tail      <= head + T'(n_rt);
            count     <= '0;
            br_flush  <= 1'b1;
            br_target <= mp_target;
         end else begin
            head     <= head + T'(n_rt);
            tail     <= tail + T'(n_dp);
            count    <= count + n_dp - n_rt;
            br_flush <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rob_nway.sv
// tb/tb_rob_nway.sv - directed self-checking bench for rob_nway
module tb_rob_nway;
   localparam int T  = 5;
   localparam int XL = 32;

   logic          clock, reset_n, flush_in;
   logic [1:0]    dp_valid, dp_ready;
   logic [9:0]    dp_dest_reg, dp_tag;
   logic [63:0]   dp_pc;
   logic [1:0]    cdb_valid, cdb_mispredict;
   logic [9:0]    cdb_tag;
   logic [63:0]   cdb_value, cdb_target;
   logic [19:0]   rd_tag;
   logic [127:0]  rd_value;
   logic [3:0]    rd_ready;
   logic [1:0]    rt_valid;
   logic [9:0]    rt_dest_reg;
   logic [63:0]   rt_value, rt_pc;
   logic          br_flush;
   logic [31:0]   br_target;
   logic [5:0]    count;

   int total = 0;
   int bad   = 0;

   rob_nway dut (
      .clock(clock), .reset_n(reset_n), .flush_in(flush_in),
      .dp_valid(dp_valid), .dp_dest_reg(dp_dest_reg), .dp_pc(dp_pc),
      .dp_ready(dp_ready), .dp_tag(dp_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
      .rd_tag(rd_tag), .rd_value(rd_value), .rd_ready(rd_ready),
      .rt_valid(rt_valid), .rt_dest_reg(rt_dest_reg), .rt_value(rt_value), .rt_pc(rt_pc),
      .br_flush(br_flush), .br_target(br_target), .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      flush_in = 0; dp_valid = 0; dp_dest_reg = 0; dp_pc = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_mispredict = 0; cdb_target = 0;
   endtask

   task automatic test_reset();
      reset_n = 1; rd_tag = 0;
      idle_inputs();
      #2 reset_n = 0;
      #1;
      total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (dp_ready !== 2'b11) begin bad++; $display("FAIL reset_dp_ready got=%b exp=11", dp_ready); end
      total++; if (dp_tag !== {5'd1, 5'd0}) begin bad++; $display("FAIL reset_dp_tag got=%h exp=%h", dp_tag, {5'd1, 5'd0}); end
      total++; if (rt_valid !== 2'b00) begin bad++; $display("FAIL reset_rt_valid got=%b exp=00", rt_valid); end
      total++; if (br_flush !== 1'b0 || br_target !== 32'd0) begin bad++; $display("FAIL reset_br got=%b/%h exp=0/0", br_flush, br_target); end
      total++; if (rd_ready !== 4'b0000) begin bad++; $display("FAIL reset_rd_ready got=%b exp=0000", rd_ready); end
      repeat (2) @(posedge clock);
      #2 reset_n = 1;
   endtask

   task automatic test_dispatch();
      dp_valid = 2'b11; dp_pc = {32'h104, 32'h100}; dp_dest_reg = {5'd2, 5'd1};
      #1;
      total++; if (dp_tag !== {5'd1, 5'd0}) begin bad++; $display("FAIL dp_first_tags got=%h exp=%h", dp_tag, {5'd1, 5'd0}); end
      tick();
      dp_valid = 0;
      #1;
      total++; if (count !== 6'd2) begin bad++; $display("FAIL dp_count got=%0d exp=2", count); end
      total++; if (dp_tag !== {5'd3, 5'd2}) begin bad++; $display("FAIL dp_next_tags got=%h exp=%h", dp_tag, {5'd3, 5'd2}); end
   endtask

   task automatic test_complete_retire();
      cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd1}; cdb_value = {32'd0, 32'd5};
      #1; tick();
      cdb_tag = {5'd0, 5'd0}; cdb_value = {32'd0, 32'd7};
      #1;
      total++; if (rt_valid !== 2'b00) begin bad++; $display("FAIL ooo_no_retire got=%b exp=00", rt_valid); end
      tick();
      cdb_valid = 0;
      #1;
      total++; if (rt_valid !== 2'b11) begin bad++; $display("FAIL pair_rt_valid got=%b exp=11", rt_valid); end
      total++; if (rt_value !== {32'd5, 32'd7}) begin bad++; $display("FAIL pair_rt_value got=%h exp=%h", rt_value, {32'd5, 32'd7}); end
      total++; if (rt_pc !== {32'h104, 32'h100}) begin bad++; $display("FAIL pair_rt_pc got=%h exp=%h", rt_pc, {32'h104, 32'h100}); end
      total++; if (rt_dest_reg !== {5'd2, 5'd1}) begin bad++; $display("FAIL pair_rt_dest got=%h exp=%h", rt_dest_reg, {5'd2, 5'd1}); end
      tick();
      total++; if (count !== 6'd0 || rt_valid !== 2'b00) begin bad++; $display("FAIL pair_drain got=%0d/%b exp=0/00", count, rt_valid); end
   endtask

   task automatic test_fill_wrap();
      logic [9:0] exp_tag;
      dp_dest_reg = 0; dp_pc = 0;
      for (int k = 0; k < 16; k++) begin
         dp_valid = 2'b11;
         exp_tag = {5'((3 + 2 * k) % 32), 5'((2 + 2 * k) % 32)};
         #1;
         total++; if (dp_tag !== exp_tag) begin bad++; $display("FAIL fill_tag_%0d got=%h exp=%h", k, dp_tag, exp_tag); end
         tick();
      end
      dp_valid = 0;
      #1;
      total++; if (count !== 6'd32) begin bad++; $display("FAIL full_count got=%0d exp=32", count); end
      total++; if (dp_ready !== 2'b00) begin bad++; $display("FAIL full_dp_ready got=%b exp=00", dp_ready); end
      cdb_valid = 2'b11; cdb_tag = {5'd3, 5'd2}; cdb_value = {32'h33, 32'h22};
      #1; tick();
      cdb_valid = 0; dp_valid = 2'b11;
      #1;
      total++; if (rt_valid !== 2'b11 || dp_ready !== 2'b00) begin bad++; $display("FAIL full_retire got=%b/%b exp=11/00", rt_valid, dp_ready); end
      tick();
      total++; if (count !== 6'd30) begin bad++; $display("FAIL reject_count got=%0d exp=30", count); end
      total++; if (dp_ready !== 2'b11 || dp_tag !== {5'd3, 5'd2}) begin bad++; $display("FAIL reopen got=%b/%h exp=11/%h", dp_ready, dp_tag, {5'd3, 5'd2}); end
      tick();
      dp_valid = 0;
      #1;
      total++; if (count !== 6'd32) begin bad++; $display("FAIL accept_next_count got=%0d exp=32", count); end
   endtask

   task automatic test_flush();
      cdb_valid = 2'b11; cdb_tag = {5'd5, 5'd4}; cdb_value = {32'h55, 32'h44};
      #1; tick();
      cdb_valid = 0; flush_in = 1;
      #1;
      total++; if (rt_valid !== 2'b00) begin bad++; $display("FAIL flush_rt_valid got=%b exp=00", rt_valid); end
      tick();
      flush_in = 0;
      #1;
      total++; if (count !== 6'd0 || br_flush !== 1'b0) begin bad++; $display("FAIL flush_state got=%0d/%b exp=0/0", count, br_flush); end
      total++; if (dp_tag !== {5'd5, 5'd4}) begin bad++; $display("FAIL flush_tail got=%h exp=%h", dp_tag, {5'd5, 5'd4}); end
   endtask

   task automatic test_mispredict();
      dp_valid = 2'b11; dp_pc = {32'h404, 32'h400};
      #1; tick();
      dp_pc = {32'h40c, 32'h408};
      #1; tick();
      dp_valid = 0;
      total++; if (count !== 6'd4) begin bad++; $display("FAIL mp_count4 got=%0d exp=4", count); end
      cdb_valid = 2'b11; cdb_tag = {5'd4, 5'd5}; cdb_value = {32'h44, 32'h55};
      cdb_mispredict = 2'b01; cdb_target = {32'h0, 32'h200};
      #1; tick();
      cdb_tag = {5'd7, 5'd6}; cdb_value = {32'h77, 32'h66}; cdb_mispredict = 0; cdb_target = 0;
      #1;
      total++; if (rt_valid !== 2'b11) begin bad++; $display("FAIL mp_rt_valid got=%b exp=11", rt_valid); end
      total++; if (rt_pc !== {32'h404, 32'h400}) begin bad++; $display("FAIL mp_rt_pc got=%h exp=%h", rt_pc, {32'h404, 32'h400}); end
      tick();
      cdb_valid = 0;
      #1;
      total++; if (br_flush !== 1'b1 || br_target !== 32'h200) begin bad++; $display("FAIL mp_redirect got=%b/%h exp=1/200", br_flush, br_target); end
      total++; if (count !== 6'd0 || rt_valid !== 2'b00) begin bad++; $display("FAIL mp_squash got=%0d/%b exp=0/00", count, rt_valid); end
      total++; if (dp_ready !== 2'b11 || dp_tag !== {5'd7, 5'd6}) begin bad++; $display("FAIL mp_tail got=%b/%h exp=11/%h", dp_ready, dp_tag, {5'd7, 5'd6}); end
      tick();
      total++; if (br_flush !== 1'b0 || rt_valid !== 2'b00) begin bad++; $display("FAIL mp_one_cycle got=%b/%b exp=0/00", br_flush, rt_valid); end
   endtask

   task automatic test_bypass();
      dp_valid = 2'b11; dp_pc = {32'h504, 32'h500};
      #1; tick();
      dp_valid = 0;
      rd_tag = {5'd7, 5'd20, 5'd6, 5'd7};
      #1;
      total++; if (rd_ready !== 4'b0000) begin bad++; $display("FAIL rd_idle got=%b exp=0000", rd_ready); end
      cdb_valid = 2'b10; cdb_tag = {5'd7, 5'd0}; cdb_value = {32'habcd, 32'h0};
      #1;
      total++; if (rd_ready !== 4'b1001 || rd_value[31:0] !== 32'habcd || rd_value[127:96] !== 32'habcd) begin
         bad++; $display("FAIL rd_bypass got=%b/%h exp=1001/abcd", rd_ready, rd_value[31:0]); end
      tick();
      cdb_valid = 0;
      #1;
      total++; if (rd_ready !== 4'b1001 || rd_value[31:0] !== 32'habcd) begin bad++; $display("FAIL rd_stored got=%b/%h exp=1001/abcd", rd_ready, rd_value[31:0]); end
      cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd20}; cdb_value = {32'h0, 32'h99};
      #1;
      total++; if (rd_ready[2] !== 1'b1 || rd_value[95:64] !== 32'h99) begin bad++; $display("FAIL rd_stale_bypass got=%b/%h exp=1/99", rd_ready[2], rd_value[95:64]); end
      tick();
      cdb_valid = 0;
      #1;
      total++; if (rd_ready[2] !== 1'b0 || count !== 6'd2) begin bad++; $display("FAIL stale_ignored got=%b/%0d exp=0/2", rd_ready[2], count); end
   endtask

   task automatic test_reset_mid();
      cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd6}; cdb_value = {32'h0, 32'h66};
      cdb_mispredict = 2'b01; cdb_target = {32'h0, 32'h300};
      #1; tick();
      idle_inputs();
      #1;
      total++; if (rt_valid !== 2'b01 || rt_value[31:0] !== 32'h66) begin bad++; $display("FAIL mp_cut got=%b/%h exp=01/66", rt_valid, rt_value[31:0]); end
      tick();
      total++; if (br_flush !== 1'b1 || br_target !== 32'h300 || count !== 6'd0) begin
         bad++; $display("FAIL mp2_redirect got=%b/%h/%0d exp=1/300/0", br_flush, br_target, count); end
      #1 reset_n = 0;
      #1;
      total++; if (br_flush !== 1'b0 || br_target !== 32'd0) begin bad++; $display("FAIL rst_mid_br got=%b/%h exp=0/0", br_flush, br_target); end
      total++; if (count !== 6'd0 || dp_tag !== {5'd1, 5'd0} || dp_ready !== 2'b11) begin
         bad++; $display("FAIL rst_mid_ptr got=%0d/%h/%b exp=0/%h/11", count, dp_tag, dp_ready, {5'd1, 5'd0}); end
      total++; if (rt_valid !== 2'b00 || rd_ready !== 4'b0000) begin bad++; $display("FAIL rst_mid_out got=%b/%b exp=00/0000", rt_valid, rd_ready); end
      #3 reset_n = 1;
   endtask

   initial begin
      test_reset();
      test_dispatch();
      test_complete_retire();
      test_fill_wrap();
      test_flush();
      test_mispredict();
      test_bypass();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rob_nway.md
# rob_nway

Parametrised, multi-issue reorder buffer for the out-of-order core; successor to the single-issue ROB.
- Accepts up to DISPATCH_W instructions per cycle from dispatch, takes up to CDB_W completions per cycle, and retires up to RETIRE_W completed entries in order to the architectural register file.
- Resolves branch mispredicts at retire with a registered flush/redirect, and serves operand lookups with CDB bypass for the RS.

## Interface
- ROB_DEPTH, 32, entries; power of two, ≥ max(4, DISPATCH_W, RETIRE_W); T = $clog2(ROB_DEPTH)
- DISPATCH_W, 2, dispatch lanes
- RETIRE_W, 2, retire lanes
- CDB_W, 2, completion broadcast lanes
- XLEN, 32, data width
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush_in  in  1  external squash (exception/interrupt); empties ROB at next edge
- dp_valid  in  DISPATCH_W  lane request; must be contiguous from lane 0
- dp_dest_reg  in  DISPATCH_W×5  destination arch reg (0 = none)
- dp_pc  in  DISPATCH_W×XLEN  instruction PC
- dp_ready  out  DISPATCH_W  lane i ready iff free entries > i
- dp_tag  out  DISPATCH_W×T  tag for lane i = (tail+i) mod ROB_DEPTH
- cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target  in  CDB_W×{1,T,XLEN,1,XLEN}  completions
- rd_tag  in  2·DISPATCH_W×T  operand lookup tags
- rd_value / rd_ready  out  2·DISPATCH_W×{XLEN,1}  entry value / completed flag
- rt_valid  out  RETIRE_W  retire lane valid
- rt_dest_reg, rt_value, rt_pc  out  RETIRE_W×{5,XLEN,XLEN}  retiring entry fields
- br_flush  out  1  one-cycle registered mispredict redirect
- br_target  out  XLEN  redirect PC, valid with br_flush
- count  out  T+1  occupied entries

## Operation
- State: head, tail (T bits, wrap), count (T+1 bits), per-entry {valid, complete, mispredict, dest_reg, pc, value, target}.
- Dispatch: accepted lanes = dp_valid & dp_ready. Each accepted lane writes entry tail+i with valid=1 and complete=0. tail += accepted; wraps at ROB_DEPTH.
- Completion: each cdb lane with valid entry[cdb_tag] sets complete, value, mispredict, target. A tag with valid=0 is stale and is ignored. Two lanes carrying the same tag is illegal; the higher lane index wins.
- Retire lane j valid iff all hold:
  - count > j;
  - entries head..head+j are all complete;
  - no lane < j carries mispredict.
  - Retiring entries clear valid; head += retired.
- A mispredicting entry retires normally (its value is written back). At that same edge:
  - all younger entries are invalidated;
  - tail = head_n; count = 0;
  - same-cycle dispatch is dropped;
  - br_flush = 1 and br_target = entry.target for the following cycle.
- flush_in: same invalidation (head, tail kept; tail=head; count=0; dispatch and retire that cycle dropped). No br_flush. Takes priority over mispredict.
- rd lookup, combinational:
  - rd_value = entry.value; rd_ready = entry.complete;
  - a matching cdb lane in the same cycle overrides both (highest lane wins).
- count_n = count + dispatched − retired.

## Timing
- Reset (reset_n=0, async):
  - all entries invalid; head = tail = count = 0;
  - dp_ready all 1; dp_tag lane i = i;
  - rt_valid = 0; br_flush = 0; br_target = 0; rd_ready = 0.
- Deassertion is synchronised externally; the first edge after reset may dispatch.
- dp_tag, dp_ready, rt_*, rd_*: combinational from registered state (+CDB for rd).
- Dispatch at edge N → earliest CDB completion in cycle N+1 → earliest rt_valid in cycle N+2.
- Mispredict retire at edge N → br_flush high in cycle N+1 only; dp_ready recomputed from count=0.
- Slots freed by retire are not reusable until the next cycle: dp_ready uses registered count.
- Full (count = ROB_DEPTH): dp_ready = 0. Empty: rt_valid = 0.
- Reset asserted mid-operation clears everything immediately; pending br_flush is lost.

## Structure
- Shared package rob_pkg:
  - typedef rob_entry_t;
  - typedef rob_tag_t (T bits);
  - localparams for the pointer/count widths.
- Sub-module rob_retire_sel: computes the retire mask and mispredict cut from head-ordered complete/mispredict vectors.

## Test plan
- Reset, dispatch 2 (pcs 0x100, 0x104) → tags 0,1; count=2; dp_tag shows 2,3 next cycle.
- Complete tag 1 then tag 0 (values 5, 7) → tag 0 and tag 1 retire together in one cycle, rt_value={7,5}, then count=0.
- Fill to 32 → dp_ready=0. Retire 2 and dispatch in the same cycle → dispatch rejected that cycle, accepted the next. Tags wrap 31→0.
- 4 entries; tag 1 completes with mispredict, target 0x200; all complete → tags 0,1 retire; tags 2,3 never retire. br_flush=1 for exactly one cycle with br_target=0x200; count=0.
- CDB on tag 3 while rd_tag=3 in the same cycle → rd_ready=1 and rd_value=cdb_value. CDB to an invalid tag → no state change.
- flush_in while entries are complete at head → no rt_valid that cycle, count=0, br_flush stays 0. Assert reset_n=0 mid-stream → all outputs return to reset values immediately.
